// File: rtl/btn_conditioner.sv
// Button/switch conditioner: 2-flop sync, sampled debounce,
// press pulses and a RUN/HOLD pause toggle.
// Ports:
//   clock_in, reset (async, active-high)
//   rst_button, pause_button, adj_switch, sel_switch : raw inputs
//   clr_pulse, pause_pulse : one-cycle press pulses
//   paused : pause state, adj/sel : debounced switch levels
module btn_conditioner #(
  parameter int SAMPLE_DIV     = 100000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clock_in,
  input  logic reset,
  input  logic rst_button,
  input  logic pause_button,
  input  logic adj_switch,
  input  logic sel_switch,
  output logic clr_pulse,
  output logic pause_pulse,
  output logic paused,
  output logic adj,
  output logic sel
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // channel order: 0 rst, 1 pause, 2 adj, 3 sel
  logic [3:0] raw_bus;
  logic [3:0] sync_a;
  logic [3:0] sync_b;

  logic [CW-1:0] cnt;
  logic          sample_tick;

  logic [3:0] stable;
  logic [3:0] agree [4];
  logic [1:0] stable_d;

  logic [0:0] state;

  assign raw_bus = {sel_switch, adj_switch,
                    pause_button, rst_button};

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_bus;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sample_tick = (cnt == LAST);

  // agree counts consecutive samples that disagree
  // with the stable level; any agreeing sample restarts it
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) begin
        agree[i] <= '0;
      end
    end else if (sample_tick) begin
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == stable[i]) begin
          agree[i] <= '0;
        end else if (agree[i] + 4'd1 == DT) begin
          stable[i] <= sync_b[i];
          agree[i]  <= '0;
        end else begin
          agree[i] <= agree[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      stable_d    <= '0;
      clr_pulse   <= 1'b0;
      pause_pulse <= 1'b0;
    end else begin
      stable_d    <= stable[1:0];
      clr_pulse   <= stable[0] & ~stable_d[0];
      pause_pulse <= stable[1] & ~stable_d[1];
    end
  end

  // clear wins over a coincident pause press
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else if (clr_pulse) begin
      state <= RUN;
    end else if (pause_pulse) begin
      state <= (state == RUN) ? HOLD : RUN;
    end
  end

  assign paused = (state == HOLD);
  assign adj    = stable[2];
  assign sel    = stable[3];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus
// random input streams against a sample-history model.
module tb_btn_conditioner;

  localparam int SD = 2;
  localparam int DT = 3;

  logic clock_in = 1'b0;
  logic reset = 1'b1;
  logic rst_button = 1'b0;
  logic pause_button = 1'b0;
  logic adj_switch = 1'b0;
  logic sel_switch = 1'b0;
  logic clr_pulse;
  logic pause_pulse;
  logic paused;
  logic adj;
  logic sel;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .SAMPLE_DIV(SD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .rst_button(rst_button),
    .pause_button(pause_button),
    .adj_switch(adj_switch),
    .sel_switch(sel_switch),
    .clr_pulse(clr_pulse),
    .pause_pulse(pause_pulse),
    .paused(paused),
    .adj(adj),
    .sel(sel)
  );

  always #5 clock_in = ~clock_in;

  // reference model: k = rising edges since reset release
  int k;
  logic [3:0] raw_h [$];
  logic [3:0] smp [$];
  logic [3:0] m_stable;
  logic [3:0] m_rose;
  logic m_clr;
  logic m_pz;
  logic m_paused;

  // observed-event trackers
  int n_clr, n_pz, n_both;
  int pz_k, paused_k, adj_k, sel_k;

  logic [3:0] r;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d",
             tag, obs, lo, hi);
    end
  endtask

  task automatic model_reset();
    k = 0;
    raw_h.delete();
    smp.delete();
    m_stable = '0;
    m_rose = '0;
    m_clr = 1'b0;
    m_pz = 1'b0;
    m_paused = 1'b0;
  endtask

  // a level flips when the last DT samples all
  // disagree with it; samples start one per SD edges,
  // the synchronizer delays raw input by two edges
  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] s;
    logic [3:0] prev;
    bit all;
    k++;
    raw_h.push_back(raw);
    prev = m_stable;
    if (m_clr) m_paused = 1'b0;
    else if (m_pz) m_paused = ~m_paused;
    m_clr = m_rose[0];
    m_pz = m_rose[1];
    if (k % SD == 0) begin
      s = (k >= 3) ? raw_h[k-3] : 4'b0;
      smp.push_back(s);
      for (int c = 0; c < 4; c++) begin
        all = (smp.size() >= DT);
        for (int i = 1; i <= DT; i++) begin
          if (all && smp[smp.size()-i][c] == m_stable[c])
            all = 0;
        end
        if (all) m_stable[c] = s[c];
      end
    end
    m_rose = m_stable & ~prev;
  endtask

  task automatic clear_trk();
    n_clr = 0;
    n_pz = 0;
    n_both = 0;
    pz_k = -1;
    paused_k = -1;
    adj_k = -1;
    sel_k = -1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clr"}, int'(clr_pulse), int'(m_clr));
    chk({tag, ".pz"}, int'(pause_pulse), int'(m_pz));
    chk({tag, ".paused"}, int'(paused), int'(m_paused));
    chk({tag, ".adj"}, int'(adj), int'(m_stable[2]));
    chk({tag, ".sel"}, int'(sel), int'(m_stable[3]));
  endtask

  // raw = {sel, adj, pause, rst}; called at a negedge
  task automatic cyc(input string tag, input logic [3:0] raw);
    {sel_switch, adj_switch, pause_button, rst_button} = raw;
    @(posedge clock_in);
    model_edge(raw);
    #1;
    check_all(tag);
    if (clr_pulse) n_clr++;
    if (pause_pulse) begin
      n_pz++;
      if (pz_k < 0) pz_k = k;
    end
    if (clr_pulse && pause_pulse) n_both++;
    if (paused && paused_k < 0) paused_k = k;
    if (adj && adj_k < 0) adj_k = k;
    if (sel && sel_k < 0) sel_k = k;
    @(negedge clock_in);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst.clr"}, int'(clr_pulse), 0);
    chk({tag, ".rst.pz"}, int'(pause_pulse), 0);
    chk({tag, ".rst.paused"}, int'(paused), 0);
    chk({tag, ".rst.adj"}, int'(adj), 0);
    chk({tag, ".rst.sel"}, int'(sel), 0);
    repeat (2) begin
      @(posedge clock_in);
      #1;
      chk({tag, ".rsth"},
          int'({clr_pulse, pause_pulse, paused, adj, sel}), 0);
    end
    @(negedge clock_in);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_trk();
    @(negedge clock_in);

    // single long pause press
    do_reset("s1");
    clear_trk();
    repeat (20) cyc("s1", 4'b0010);
    chk("s1 pulses", n_pz, 1);
    chk_rng("s1 latency", pz_k, 7, 9);
    chk("s1 paused edge", paused_k, pz_k + 1);
    repeat (10) cyc("s1", 4'b0000);
    chk("s1 paused end", int'(paused), 1);

    // short glitch
    do_reset("s2");
    clear_trk();
    repeat (3) cyc("s2", 4'b0010);
    repeat (15) cyc("s2", 4'b0000);
    chk("s2 pulses", n_pz, 0);
    chk("s2 paused", paused_k, -1);

    // two presses toggle back
    do_reset("s3");
    clear_trk();
    repeat (20) cyc("s3", 4'b0010);
    repeat (20) cyc("s3", 4'b0000);
    chk("s3 mid paused", int'(paused), 1);
    repeat (20) cyc("s3", 4'b0010);
    repeat (20) cyc("s3", 4'b0000);
    chk("s3 pulses", n_pz, 2);
    chk("s3 end paused", int'(paused), 0);

    // clear and pause together while paused
    do_reset("s4");
    clear_trk();
    repeat (20) cyc("s4", 4'b0010);
    repeat (20) cyc("s4", 4'b0000);
    chk("s4 pre paused", int'(paused), 1);
    clear_trk();
    repeat (20) cyc("s4", 4'b0011);
    chk("s4 both", n_both, 1);
    chk("s4 clr", n_clr, 1);
    chk("s4 pz", n_pz, 1);
    chk("s4 paused", int'(paused), 0);
    repeat (10) cyc("s4", 4'b0000);

    // adj chatter then steady
    do_reset("s5");
    clear_trk();
    for (int i = 0; i < 40; i++)
      cyc("s5", {1'b0, (i % 2 == 0), 2'b00});
    chk("s5 chatter", adj_k, -1);
    repeat (15) cyc("s5", 4'b0100);
    chk_rng("s5 rise", adj_k - 41, 5, 7);

    // reset mid-qualification of sel
    do_reset("s6");
    clear_trk();
    repeat (6) cyc("s6", 4'b1000);
    chk("s6 pre", sel_k, -1);
    do_reset("s6r");
    clear_trk();
    chk("s6 after rst", int'(sel), 0);
    repeat (10) cyc("s6", 4'b1000);
    chk("s6 rise", sel_k, 8);

    // random streams
    do_reset("rnd");
    r = '0;
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) r[c] = ~r[c];
      if (n == 250) do_reset("rndr");
      cyc("rnd", r);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000, sets the number of clock_in cycles between debounce samples (>=2).
REQ-002 Parameter DEBOUNCE_TICKS, default 4, sets the number of consecutive agreeing samples needed to change a stable level (2..15).
REQ-003 Port clock_in, input, 1 bit: master clock, rising-edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port rst_button, input, 1 bit: raw, asynchronous clear pushbutton.
REQ-006 Port pause_button, input, 1 bit: raw, asynchronous pause pushbutton.
REQ-007 Port adj_switch, input, 1 bit: raw, asynchronous adjust slide switch.
REQ-008 Port sel_switch, input, 1 bit: raw, asynchronous select slide switch.
REQ-009 Port clr_pulse, output, 1 bit: one-cycle pulse per debounced rst_button press.
REQ-010 Port pause_pulse, output, 1 bit: one-cycle pulse per debounced pause_button press.
REQ-011 Port paused, output, 1 bit: pause state level (1 = stopwatch frozen).
REQ-012 Port adj, output, 1 bit: debounced adj_switch level.
REQ-013 Port sel, output, 1 bit: debounced sel_switch level.

Function
REQ-014 All logic SHALL be clocked on the clock_in rising edge; no derived clocks and no logic clocked by data signals.
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer before use.
REQ-016 The sample counter SHALL count 0..SAMPLE_DIV-1 and wrap; sample_tick SHALL be high for exactly one cycle when the count equals SAMPLE_DIV-1.
REQ-017 Each channel SHALL hold a stable register and a 4-bit agree counter; these update only on sample_tick.
REQ-018 On sample_tick, if the synced value equals stable, the agree counter SHALL clear to 0.
REQ-019 On sample_tick, if the synced value differs from stable, the agree counter SHALL increment; when it would reach DEBOUNCE_TICKS, stable SHALL take the synced value and the counter SHALL clear.
REQ-020 A level change lasting fewer than DEBOUNCE_TICKS consecutive samples SHALL NOT change stable.
REQ-021 adj and sel SHALL equal their stable registers directly.
REQ-022 clr_pulse and pause_pulse SHALL be registered: high for exactly one cycle, in the cycle after the corresponding stable rises 0->1.
REQ-023 A falling stable edge SHALL produce no pulse; a button held indefinitely SHALL produce exactly one pulse.
REQ-024 The pause FSM SHALL have two states, RUN (paused=0) and HOLD (paused=1); paused SHALL be a registered output.
REQ-025 In the cycle after pause_pulse, the FSM SHALL go RUN->HOLD or HOLD->RUN.
REQ-026 In the cycle after clr_pulse, the FSM SHALL go to RUN, taking priority over a simultaneous pause_pulse.
REQ-027 Raw-to-pulse latency SHALL lie between 2+(DEBOUNCE_TICKS-1)*SAMPLE_DIV+1 and 2+DEBOUNCE_TICKS*SAMPLE_DIV+1 cycles.

Reset
REQ-028 While reset is high, all outputs SHALL be 0 and all internal state SHALL be 0: synchronizers, sample counter, stable registers, agree counters, and FSM state RUN.
REQ-029 Reset asserted mid-debounce SHALL discard partial agree counts; after release, qualification restarts from 0.
REQ-030 Reset release SHALL be synchronous to clock_in; the first sample_tick occurs SAMPLE_DIV cycles after release.

Verification (SAMPLE_DIV=2, DEBOUNCE_TICKS=3)
REQ-031 Hold pause_button=1 for 20 cycles -> exactly one pause_pulse, within cycles 7..9 after assertion; paused goes 0->1 the following cycle.
REQ-032 Hold pause_button=1 for 3 cycles, then 0 -> no pause_pulse; paused remains 0.
REQ-033 Two separated 20-cycle pause presses -> paused sequence 0->1->0, with two pause_pulses.
REQ-034 Start with paused=1; make pause_button and rst_button rise in the same cycle and hold both -> clr_pulse and pause_pulse fire in the same cycle; paused becomes 0.
REQ-035 Toggle adj_switch 1/0 every cycle for 40 cycles, then hold at 1 -> adj stays 0 throughout the toggling, then rises after 5..7 cycles of steady 1.
REQ-036 Assert reset after 2 qualifying samples of sel_switch=1, then release -> sel=0; sel rises only after 3 fresh samples post-release.
